// File: rtl/hazard_if.sv
// Hazard-detection inputs and pipeline-register controls between
// the core pipeline (master) and the hazard controller (slave).
interface hazard_if #(
  parameter int REG_SIZE  = 5,
  parameter int CNT_WIDTH = 16
);
  logic [REG_SIZE-1:0]  id_rs1;
  logic [REG_SIZE-1:0]  id_rs2;
  logic                 id_use_rs1;
  logic                 id_use_rs2;
  logic                 ex_memRead;
  logic [REG_SIZE-1:0]  ex_rd;
  logic                 ex_branch_taken;
  logic                 mem_req;
  logic                 dmem_ready;
  logic                 pc_stall;
  logic                 if_id_stall;
  logic                 id_ex_stall;
  logic                 ex_mem_stall;
  logic                 if_id_flush;
  logic                 id_ex_bubble;
  logic                 mem_wb_bubble;
  logic [1:0]           hz_state;
  logic [CNT_WIDTH-1:0] stall_count;
  logic [CNT_WIDTH-1:0] flush_count;
  logic                 mem_timeout;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output ex_memRead, ex_rd, ex_branch_taken,
    output mem_req, dmem_ready,
    input  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
    input  if_id_flush, id_ex_bubble, mem_wb_bubble,
    input  hz_state, stall_count, flush_count, mem_timeout
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  ex_memRead, ex_rd, ex_branch_taken,
    input  mem_req, dmem_ready,
    output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
    output if_id_flush, id_ex_bubble, mem_wb_bubble,
    output hz_state, stall_count, flush_count, mem_timeout
  );
endinterface

// File: rtl/hazard_controller.sv
// Load-use / memory-wait / branch-flush sequencer for the 5-stage core,
// with saturating stall/flush counters and a sticky memory-timeout flag.
module hazard_controller #(
  parameter int REG_SIZE    = 5,
  parameter int CNT_WIDTH   = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input logic     clk,
  input logic     rst,
  hazard_if.slave hz
);
  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    FLUSH      = 2'd2,
    MEM_WAIT   = 2'd3
  } hz_e;

  localparam logic [CNT_WIDTH:0] TO_LIM =
    (CNT_WIDTH+1)'(MEM_TIMEOUT);
  localparam logic [CNT_WIDTH:0] ONE =
    (CNT_WIDTH+1)'(1);

  hz_e                  sel;
  hz_e                  state_q;
  logic                 mem_hold;
  logic                 load_use;
  logic                 br;
  logic [REG_SIZE-1:0]  rd;
  logic [CNT_WIDTH-1:0] wait_q;
  logic [CNT_WIDTH-1:0] stall_q;
  logic [CNT_WIDTH-1:0] flush_q;
  logic                 to_q;
  logic [CNT_WIDTH:0]   wait_nx;

  assign rd       = hz.ex_rd;
  assign br       = hz.ex_branch_taken;
  assign mem_hold = hz.mem_req & ~hz.dmem_ready;
  assign load_use = hz.ex_memRead & (rd != '0) &
    ((hz.id_use_rs1 & (rd == hz.id_rs1)) |
     (hz.id_use_rs2 & (rd == hz.id_rs2)));
  assign wait_nx  = {1'b0, wait_q} + ONE;

  // Terms are made mutually exclusive to encode the priority.
  always_comb begin
    sel = RUN;
    unique case (1'b1)
      mem_hold:                    sel = MEM_WAIT;
      !mem_hold && br:             sel = FLUSH;
      !mem_hold && !br && load_use: sel = LOAD_STALL;
      default:                     sel = RUN;
    endcase
  end

  assign hz.pc_stall      = (sel == MEM_WAIT) || (sel == LOAD_STALL);
  assign hz.if_id_stall   = (sel == MEM_WAIT) || (sel == LOAD_STALL);
  assign hz.id_ex_stall   = (sel == MEM_WAIT);
  assign hz.ex_mem_stall  = (sel == MEM_WAIT);
  assign hz.mem_wb_bubble = (sel == MEM_WAIT);
  assign hz.if_id_flush   = (sel == FLUSH);
  assign hz.id_ex_bubble  = (sel == FLUSH) || (sel == LOAD_STALL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      wait_q  <= '0;
      stall_q <= '0;
      flush_q <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= sel;
      if (mem_hold) begin
        if (!wait_nx[CNT_WIDTH])
          wait_q <= wait_nx[CNT_WIDTH-1:0];
        if (wait_nx == TO_LIM)
          to_q <= 1'b1;
      end else begin
        wait_q <= '0;
      end
      if (hz.pc_stall && stall_q != '1)
        stall_q <= stall_q + 1'b1;
      if (hz.if_id_flush && flush_q != '1)
        flush_q <= flush_q + 1'b1;
    end
  end

  assign hz.hz_state    = state_q;
  assign hz.stall_count = stall_q;
  assign hz.flush_count = flush_q;
  assign hz.mem_timeout = to_q;
endmodule

// File: tb/tb_hazard_controller.sv
// Directed scoreboard bench for hazard_controller with small
// counters (CNT_WIDTH=4) and MEM_TIMEOUT=4.
module tb_hazard_controller;
  localparam int RS = 5;
  localparam int CW = 4;
  localparam int TO = 4;

  localparam logic [6:0] C_RUN = 7'b0000000;
  localparam logic [6:0] C_LS  = 7'b1100010;
  localparam logic [6:0] C_FL  = 7'b0000110;
  localparam logic [6:0] C_MW  = 7'b1111001;

  typedef struct packed {
    logic [6:0]    c;
    logic [1:0]    s;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
    logic          to;
  } exp_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  exp_t q[$];

  logic [1:0]    m_s;
  logic [CW-1:0] m_sc;
  logic [CW-1:0] m_fc;
  logic          m_to;
  int            m_w;

  hazard_if #(.REG_SIZE(RS), .CNT_WIDTH(CW)) hz ();

  hazard_controller #(
    .REG_SIZE(RS), .CNT_WIDTH(CW), .MEM_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drv(
    input logic [RS-1:0] rs1, input logic [RS-1:0] rs2,
    input logic u1, input logic u2, input logic mr,
    input logic [RS-1:0] rd, input logic br,
    input logic mq, input logic dr
  );
    hz.id_rs1 = rs1;
    hz.id_rs2 = rs2;
    hz.id_use_rs1 = u1;
    hz.id_use_rs2 = u2;
    hz.ex_memRead = mr;
    hz.ex_rd = rd;
    hz.ex_branch_taken = br;
    hz.mem_req = mq;
    hz.dmem_ready = dr;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  // One cycle: push expectation, compare at negedge, advance the model.
  task automatic step(
    input string tag, input logic r,
    input logic [6:0] ec, input logic [1:0] es
  );
    exp_t e;
    exp_t g;
    logic [6:0] oc;
    rst = r;
    e = '{c: ec, s: m_s, sc: m_sc, fc: m_fc, to: m_to};
    q.push_back(e);
    @(negedge clk);
    g = q.pop_front();
    oc = {hz.pc_stall, hz.if_id_stall, hz.id_ex_stall,
          hz.ex_mem_stall, hz.if_id_flush, hz.id_ex_bubble,
          hz.mem_wb_bubble};
    chk({tag, ".ctrl"}, int'(oc), int'(g.c));
    chk({tag, ".state"}, int'(hz.hz_state), int'(g.s));
    chk({tag, ".stall_cnt"}, int'(hz.stall_count), int'(g.sc));
    chk({tag, ".flush_cnt"}, int'(hz.flush_count), int'(g.fc));
    chk({tag, ".timeout"}, int'(hz.mem_timeout), int'(g.to));
    if (r) begin
      m_s = 0; m_sc = 0; m_fc = 0; m_to = 0; m_w = 0;
    end else begin
      m_s = es;
      if (ec[6] && m_sc != 4'hF) m_sc = m_sc + 1'b1;
      if (ec[2] && m_fc != 4'hF) m_fc = m_fc + 1'b1;
      if (ec[0]) begin
        if (m_w + 1 == TO) m_to = 1'b1;
        m_w = m_w + 1;
      end else begin
        m_w = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    m_s = 0; m_sc = 0; m_fc = 0; m_to = 0; m_w = 0;
    rst = 1'b1;
    idle();
    @(posedge clk);
    #1;
    step("rst0", 1, C_RUN, 0);
    step("rst1", 0, C_RUN, 0);

    drv(5, 0, 1, 0, 1, 5, 0, 0, 0);
    step("lu", 0, C_LS, 1);
    idle();
    step("lu_after", 0, C_RUN, 0);

    drv(0, 0, 1, 0, 1, 0, 0, 0, 0);
    step("x0", 0, C_RUN, 0);
    drv(0, 7, 0, 0, 1, 7, 0, 0, 0);
    step("rs2_unused", 0, C_RUN, 0);
    drv(0, 7, 0, 1, 1, 7, 0, 0, 1);
    step("rs2_used", 0, C_LS, 1);
    drv(9, 0, 1, 0, 0, 9, 0, 0, 0);
    step("no_load", 0, C_RUN, 0);

    drv(5, 0, 1, 0, 1, 5, 1, 0, 0);
    step("br_lu", 0, C_FL, 2);
    idle();
    step("br_after", 0, C_RUN, 0);

    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 0, 0, 0, 0, 1, 1, 0);
      step("mw", 0, C_MW, 3);
    end
    drv(0, 0, 0, 0, 0, 0, 1, 1, 1);
    step("mw_release", 0, C_FL, 2);
    drv(0, 0, 0, 0, 0, 0, 0, 1, 1);
    step("mreq_ready", 0, C_RUN, 0);
    idle();
    step("mw_after", 0, C_RUN, 0);

    step("rst_to", 1, C_RUN, 0);
    for (int i = 0; i < 6; i++) begin
      drv(0, 0, 0, 0, 0, 0, 0, 1, 0);
      step("to_wait", 0, C_MW, 3);
    end
    drv(0, 0, 0, 0, 0, 0, 0, 1, 1);
    step("to_release", 0, C_RUN, 0);
    idle();
    step("to_sticky0", 0, C_RUN, 0);
    step("to_sticky1", 0, C_RUN, 0);
    step("to_rst", 1, C_RUN, 0);
    step("to_cleared", 0, C_RUN, 0);

    for (int i = 0; i < 20; i++) begin
      drv(3, 0, 1, 0, 1, 3, 0, 0, 0);
      step("sat", 0, C_LS, 1);
    end
    idle();
    step("sat_hold", 0, C_RUN, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("rmw0", 0, C_MW, 3);
    step("rmw_rst", 1, C_MW, 3);
    idle();
    step("post_rst", 0, C_RUN, 0);
    step("post_rst1", 0, C_RUN, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
